word_byte_serializer: RTL and testbench
=======================================

Name: word_byte_serializer

Overview:
- Downstream consumer of the 32-bit word splitter.
- Accepts one 32-bit word per handshake and emits its bytes one per cycle over a valid/ready byte stream, most-significant byte first by default.
- Supports a per-word byte length (1-4) and flags the final byte of each word.
- Sustains one byte per cycle across word boundaries, with no bubble.

Parameters:
- MSB_FIRST, 1, 1 = emit bits [31:24] first and [7:0] last; 0 = emit [7:0] first and [31:24] last.
- CNT_W, 16, width of the sent-bytes statistics counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  word to serialize.
- in_len  input  3  number of bytes to emit, 1..4; values 0 and 5..7 are treated as 4.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  downstream accepts out_byte this cycle.
- out_byte  output  8  current byte.
- out_last  output  1  current byte is the final byte of its word.
- busy  output  1  a word is held (state SEND).
- byte_cnt  output  CNT_W  total bytes accepted downstream since reset; wraps modulo 2^CNT_W.

Behaviour:
- Registers:
  - word_q[31:0]
  - len_q[2:0] (normalized 1..4)
  - idx_q[1:0] (bytes already sent for the current word)
  - state ∈ {IDLE, SEND}
  - byte_cnt
- Reset (synchronous, reset=1 at an edge): state=IDLE, word_q=0, len_q=0, idx_q=0, byte_cnt=0.
  - Outputs after reset: out_valid=0, out_byte=0, out_last=0, busy=0.
  - in_ready=1 in the first cycle after reset is released.
  - Reset mid-word discards the remaining bytes; no partial output follows.
- Handshakes:
  - A word is accepted on an edge where in_valid & in_ready.
  - A byte is transferred on an edge where out_valid & out_ready.
- out_valid = (state==SEND). busy = (state==SEND).
- out_byte is combinational from word_q and idx_q:
  - MSB_FIRST=1: byte k is word_q[31-8k -: 8].
  - MSB_FIRST=0: byte k is word_q[8k +: 8].
  - out_byte is forced to 0 when out_valid=0.
- out_last = out_valid & (idx_q == len_q-1).
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
  - This is a combinational path from out_ready to in_ready; it is allowed.
- IDLE:
  - On accept: word_q<=in_data, len_q<=norm(in_len), idx_q<=0, state<=SEND.
  - No accept: remain IDLE.
- SEND:
  - Transfer with out_last=0: idx_q<=idx_q+1.
  - Transfer with out_last=1 and a simultaneous word accept: load the new word, idx_q<=0, stay in SEND. There is no idle cycle between words.
  - Transfer with out_last=1 and no accept: state<=IDLE, idx_q<=0.
  - No transfer (out_ready=0): hold all state; out_byte and out_last stay stable.
- byte_cnt increments by 1 on every byte transfer; it wraps from all-ones to 0.
- Latency: the first byte of an accepted word is valid in the cycle after acceptance.
- Throughput:
  - A len=n word occupies exactly n transfer cycles under continuous out_ready.
  - Back-to-back words stream at 1 byte/cycle.
- in_data and in_len are sampled only at acceptance; changes while in_ready=0 are ignored.

Test Plan:
- Reset release, then in_data=0x12345678, len=4, out_ready=1 held: out_byte = 12,34,56,78 on 4 consecutive cycles; out_last only on 78; byte_cnt=4; busy returns to 0.
- MSB_FIRST=0, same word, len=4: bytes are 78,56,34,12; out_last on 12.
- Two words 0xAABBCCDD (len=2) then 0x01020304 (len=3), in_valid held, out_ready=1: stream AA,BB,01,02,03 with no gap; out_last on BB and 03; in_ready=1 in the BB cycle.
- Backpressure: word 0xCAFEF00D, len=4; out_ready=0 for 3 cycles after the first byte: out_byte holds CA and out_valid stays 1; in_ready=0 throughout; afterwards FE,F0,0D; byte_cnt=4.
- in_len=0 with 0x11223344: treated as 4, all four bytes emitted. in_len=1 with 0x99887766: single byte 99 with out_last=1.
- Reset asserted after the second byte of 0xDEADBEEF: next cycle out_valid=0, byte_cnt=0, in_ready=1; the following word 0x0000FFFF (len=4) starts at 00.

Source files
------------

// File: rtl/word_byte_serializer.sv
// word_byte_serializer
//
// Takes one 32-bit word per valid/ready handshake and sends its bytes
// downstream, one byte per cycle, on a valid/ready byte stream. Each word
// carries its own byte count (1..4). The final byte of a word is flagged
// with out_last. When the last byte is taken, the next word can be loaded
// in the same cycle, so words stream back to back with no idle cycle.
//
// Parameters
//   MSB_FIRST : 1 = send bits [31:24] first; 0 = send bits [7:0] first
//   CNT_W     : width of the running count of bytes sent
//
// Ports
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   in_valid  : upstream word present
//   in_ready  : block can take a word this cycle
//   in_data   : word to serialize
//   in_len    : bytes to send, 1..4 (0 and 5..7 mean 4)
//   out_valid : out_byte is valid
//   out_ready : downstream takes out_byte this cycle
//   out_byte  : current byte (0 when out_valid is low)
//   out_last  : current byte is the final byte of its word
//   busy      : a word is being sent
//   byte_cnt  : bytes taken downstream since reset, wraps around
module word_byte_serializer #(
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [2:0]       in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state, state_d;
    logic [31:0]       word_q, word_d;
    logic [2:0]        len_q, len_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  byte_cnt_q;

    logic accept;
    logic xfer;

    // Map the raw length field onto 1..4; anything outside 1..4 means a
    // full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        logic [2:0] r;
        if (len >= 3'd1 && len <= 3'd4) begin
            r = len;
        end else begin
            r = 3'd4;
        end
        return r;
    endfunction

    // Byte k of the word in send order. For MSB-first order, send index k
    // lives in byte lane 3-k, which is simply the bitwise inverse of k.
    function automatic logic [7:0] pick_byte(input logic [31:0] w,
                                             input logic [1:0]  k);
        logic [1:0] lane;
        logic [7:0] b;
        lane = (MSB_FIRST != 0) ? ~k : k;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_byte  = out_valid ? pick_byte(word_q, idx_q) : 8'h00;
    assign out_last  = out_valid && ({1'b0, idx_q} == (len_q - 3'd1));

    // A new word can be taken while idle, or in the same cycle the last
    // byte of the current word leaves; this is what removes the bubble.
    assign in_ready  = (state == IDLE) || (out_valid && out_ready && out_last);

    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign byte_cnt  = byte_cnt_q;

    always_comb begin
        state_d = state;
        word_d  = word_q;
        len_d   = len_q;
        idx_d   = idx_q;

        case (state)
            IDLE: begin
                if (accept) begin
                    word_d  = in_data;
                    len_d   = norm_len(in_len);
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (!out_last) begin
                        idx_d = idx_q + 2'd1;
                    end else if (accept) begin
                        word_d  = in_data;
                        len_d   = norm_len(in_len);
                        idx_d   = 2'd0;
                        state_d = SEND;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_q     <= 32'h0;
            len_q      <= 3'd0;
            idx_q      <= 2'd0;
            byte_cnt_q <= '0;
        end else begin
            state  <= state_d;
            word_q <= word_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
            if (xfer) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
module tb_word_byte_serializer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [2:0]  in_len;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_last_a, busy_a;
    logic [7:0]  out_byte_a;
    logic [15:0] byte_cnt_a;

    logic        in_ready_b, out_valid_b, out_last_b, busy_b;
    logic [7:0]  out_byte_b;
    logic [15:0] byte_cnt_b;

    int n_cmp;
    int n_bad;

    word_byte_serializer #(.MSB_FIRST(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_len(in_len),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_byte(out_byte_a), .out_last(out_last_a),
        .busy(busy_a), .byte_cnt(byte_cnt_a)
    );

    word_byte_serializer #(.MSB_FIRST(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_len(in_len),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_byte(out_byte_b), .out_last(out_last_b),
        .busy(busy_b), .byte_cnt(byte_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Both instances see the same word; a is MSB-first, b is LSB-first.
    task automatic exp_byte(input string tag, input logic [7:0] a, input logic la,
                            input logic [7:0] b, input logic lb);
        check({tag, ".vld_a"},  32'(out_valid_a), 32'd1);
        check({tag, ".byte_a"}, 32'(out_byte_a),  32'(a));
        check({tag, ".last_a"}, 32'(out_last_a),  32'(la));
        check({tag, ".vld_b"},  32'(out_valid_b), 32'd1);
        check({tag, ".byte_b"}, 32'(out_byte_b),  32'(b));
        check({tag, ".last_b"}, 32'(out_last_b),  32'(lb));
    endtask

    task automatic exp_idle(input string tag, input logic [15:0] cnt);
        check({tag, ".vld"},   32'(out_valid_a), 32'd0);
        check({tag, ".byte"},  32'(out_byte_a),  32'd0);
        check({tag, ".last"},  32'(out_last_a),  32'd0);
        check({tag, ".busy"},  32'(busy_a),      32'd0);
        check({tag, ".rdy"},   32'(in_ready_a),  32'd1);
        check({tag, ".cnt_a"}, 32'(byte_cnt_a),  32'(cnt));
        check({tag, ".cnt_b"}, 32'(byte_cnt_b),  32'(cnt));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_len    = 3'd0;
        out_ready = 1'b1;

        tick;
        tick;
        exp_idle("rst", 16'd0);

        // Full word, MSB-first on a, LSB-first on b.
        reset    = 1'b0;
        check("rel.rdy", 32'(in_ready_a), 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        in_len   = 3'd4;
        tick;
        in_valid = 1'b0;
        check("w1.busy", 32'(busy_a), 32'd1);
        exp_byte("w1.0", 8'h12, 1'b0, 8'h78, 1'b0);
        tick;
        exp_byte("w1.1", 8'h34, 1'b0, 8'h56, 1'b0);
        tick;
        exp_byte("w1.2", 8'h56, 1'b0, 8'h34, 1'b0);
        tick;
        exp_byte("w1.3", 8'h78, 1'b1, 8'h12, 1'b1);
        tick;
        exp_idle("w1.end", 16'd4);

        // Two words back to back with no gap.
        in_valid = 1'b1;
        in_data  = 32'hAABBCCDD;
        in_len   = 3'd2;
        tick;
        in_data  = 32'h01020304;
        in_len   = 3'd3;
        exp_byte("bb.0", 8'hAA, 1'b0, 8'hDD, 1'b0);
        check("bb.0.rdy", 32'(in_ready_a), 32'd0);
        tick;
        exp_byte("bb.1", 8'hBB, 1'b1, 8'hCC, 1'b1);
        check("bb.1.rdy", 32'(in_ready_a), 32'd1);
        tick;
        in_valid = 1'b0;
        exp_byte("bb.2", 8'h01, 1'b0, 8'h04, 1'b0);
        tick;
        exp_byte("bb.3", 8'h02, 1'b0, 8'h03, 1'b0);
        tick;
        exp_byte("bb.4", 8'h03, 1'b1, 8'h02, 1'b1);
        tick;
        exp_idle("bb.end", 16'd9);

        // Backpressure holds the first byte for three cycles.
        in_valid = 1'b1;
        in_data  = 32'hCAFEF00D;
        in_len   = 3'd4;
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_byte("bp.0", 8'hCA, 1'b0, 8'h0D, 1'b0);
        check("bp.0.rdy", 32'(in_ready_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            exp_byte("bp.hold", 8'hCA, 1'b0, 8'h0D, 1'b0);
            check("bp.hold.rdy", 32'(in_ready_a), 32'd0);
            check("bp.hold.cnt", 32'(byte_cnt_a), 32'd9);
        end
        out_ready = 1'b1;
        tick;
        exp_byte("bp.1", 8'hFE, 1'b0, 8'hF0, 1'b0);
        tick;
        exp_byte("bp.2", 8'hF0, 1'b0, 8'hFE, 1'b0);
        tick;
        exp_byte("bp.3", 8'h0D, 1'b1, 8'hCA, 1'b1);
        tick;
        exp_idle("bp.end", 16'd13);

        // Length 0 means a full word.
        in_valid = 1'b1;
        in_data  = 32'h11223344;
        in_len   = 3'd0;
        tick;
        in_valid = 1'b0;
        exp_byte("l0.0", 8'h11, 1'b0, 8'h44, 1'b0);
        tick;
        exp_byte("l0.1", 8'h22, 1'b0, 8'h33, 1'b0);
        tick;
        exp_byte("l0.2", 8'h33, 1'b0, 8'h22, 1'b0);
        tick;
        exp_byte("l0.3", 8'h44, 1'b1, 8'h11, 1'b1);
        tick;
        exp_idle("l0.end", 16'd17);

        // Single-byte word.
        in_valid = 1'b1;
        in_data  = 32'h99887766;
        in_len   = 3'd1;
        tick;
        in_valid = 1'b0;
        exp_byte("l1.0", 8'h99, 1'b1, 8'h66, 1'b1);
        check("l1.0.rdy", 32'(in_ready_a), 32'd1);
        tick;
        exp_idle("l1.end", 16'd18);

        // Reset in the middle of a word drops the rest of it.
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_len   = 3'd4;
        tick;
        in_valid = 1'b0;
        exp_byte("mr.0", 8'hDE, 1'b0, 8'hEF, 1'b0);
        tick;
        exp_byte("mr.1", 8'hAD, 1'b0, 8'hBE, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_idle("mr.rst", 16'd0);
        in_valid = 1'b1;
        in_data  = 32'h0000FFFF;
        in_len   = 3'd4;
        tick;
        in_valid = 1'b0;
        exp_byte("mr.n0", 8'h00, 1'b0, 8'hFF, 1'b0);
        tick;
        exp_byte("mr.n1", 8'h00, 1'b0, 8'hFF, 1'b0);
        tick;
        exp_byte("mr.n2", 8'hFF, 1'b0, 8'h00, 1'b0);
        tick;
        exp_byte("mr.n3", 8'hFF, 1'b1, 8'h00, 1'b1);
        tick;
        exp_idle("mr.end", 16'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
